// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
  localparam int unsigned RESET_DIV_DEF = 1024;
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((64'd1 << i) < 64'(n)) r = i + 1;
    return r;
  endfunction
  function automatic logic ch_hit(input int unsigned idx, input int unsigned c, input int unsigned n);
    return (idx < n) && (idx == c);
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with a shadowed divisor that is swapped in only
// at the period wrap, so the divided clock never produces runt pulses.
module clk_div_chan #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RESET_DIV = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_div,
  input  logic             i_sync,
  output logic             o_pend,
  output logic             o_clk,
  output logic             o_stb
);
  logic [WIDTH-1:0] div_q, div_d, sh_q, sh_d, cnt_q, cnt_d;
  logic             pend_q, pend_d, clk_q, clk_d, stb_q, stb_d;
  logic             en, tick;
  logic [WIDTH:0]   half;
  assign en   = div_q != '0;
  assign tick = en && (i_sync || cnt_q == div_q - WIDTH'(1));
  // one extra bit so ceil(div/2) cannot overflow at the maximum divisor
  assign half = ({1'b0, div_q} + (WIDTH+1)'(1)) >> 1;
  always_comb begin
    div_d  = div_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    cnt_d  = (en && !tick) ? cnt_q + WIDTH'(1) : '0;
    stb_d  = en && cnt_q == '0;
    clk_d  = en && ({1'b0, cnt_q} < half);
    if (tick) begin
      div_d  = i_wr ? i_wr_div : pend_q ? sh_q : div_q;
      pend_d = 1'b0;
    end else begin
      if (!en && pend_q) begin
        div_d  = sh_q;
        pend_d = 1'b0;
      end
      if (i_wr) begin
        sh_d   = i_wr_div;
        pend_d = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q  <= WIDTH'(RESET_DIV);
      sh_q   <= WIDTH'(RESET_DIV);
      cnt_q  <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      stb_q  <= stb_d;
    end
  end
  assign o_pend = pend_q;
  assign o_clk  = clk_q;
  assign o_stb  = stb_q;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: CHANNELS independent run-time programmable clock/strobe dividers.
// Define CLK_DIV_MULTI_SYNC_EN to add i_sync, which realigns all enabled channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RESET_DIV = RESET_DIV_DEF,
  localparam int unsigned CH_W     = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [WIDTH-1:0]    i_wr_div,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic                i_sync,
`endif
  output logic [CHANNELS-1:0] o_pend,
  output logic [CHANNELS-1:0] o_clk,
  output logic [CHANNELS-1:0] o_stb
);
  logic sync;
`ifdef CLK_DIV_MULTI_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    clk_div_chan #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wr     (i_wr && ch_hit(32'(i_wr_ch), c, CHANNELS)),
      .i_wr_div (i_wr_div),
      .i_sync   (sync),
      .o_pend   (o_pend[c]),
      .o_clk    (o_clk[c]),
      .o_stb    (o_stb[c])
    );
  end
endmodule
